cmd_decoder: RTL

- Front-end stage that sits directly upstream of the per-bank timing FSMs.
- Samples DDR4-style command pins (cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, a10) and emits registered one-cycle command strobes.
- Per-bank strobes drive the matching bank FSM's ACT/RD/RDA/WR/WRA/PR inputs; broadcast strobes drive PRA/REF/SRF/PD/PDX/MRW/CKEH/CKEL on all banks.
- Tracks the rank power mode so CKE edges are classified correctly and illegal commands are counted.

---
 rtl/cmd_decoder_if.sv | 62 ++++++
 rtl/cmd_decoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_decoder_if.sv
// -----------------------------------------------------------------------------
// cmd_decoder_if
// Bundles the DDR4-style command pins and the decoded strobe outputs of
// cmd_decoder.
//   master : command source. Drives i_* pins and receives o_* strobes.
//   slave  : the decoder. Samples i_* pins and drives o_* strobes.
// Pins   : i_cke, i_cs_n, i_act_n, i_ras_n, i_cas_n, i_we_n, i_bg, i_ba,
//          i_a10, i_par
// Strobes: o_act/o_rd/o_rda/o_wr/o_wra/o_pr (NBANKS-wide, one-hot per bank),
//          o_pra/o_ref/o_srf/o_pd/o_pdx/o_mrw/o_ckeh/o_ckel (broadcast),
//          o_pmode (power mode), o_err (illegal pulse),
//          o_err_cnt (saturating illegal count)
// -----------------------------------------------------------------------------
interface cmd_decoder_if #(
  parameter int BGW = 2,
  parameter int BAW = 2
);
  localparam int NBANKS = 2**(BGW+BAW);

  logic              i_cke;
  logic              i_cs_n;
  logic              i_act_n;
  logic              i_ras_n;
  logic              i_cas_n;
  logic              i_we_n;
  logic [BGW-1:0]    i_bg;
  logic [BAW-1:0]    i_ba;
  logic              i_a10;
  logic              i_par;

  logic [NBANKS-1:0] o_act;
  logic [NBANKS-1:0] o_rd;
  logic [NBANKS-1:0] o_rda;
  logic [NBANKS-1:0] o_wr;
  logic [NBANKS-1:0] o_wra;
  logic [NBANKS-1:0] o_pr;
  logic              o_pra;
  logic              o_ref;
  logic              o_srf;
  logic              o_pd;
  logic              o_pdx;
  logic              o_mrw;
  logic              o_ckeh;
  logic              o_ckel;
  logic [1:0]        o_pmode;
  logic              o_err;
  logic [7:0]        o_err_cnt;

  modport master (
    output i_cke, i_cs_n, i_act_n, i_ras_n, i_cas_n, i_we_n, i_bg, i_ba, i_a10, i_par,
    input  o_act, o_rd, o_rda, o_wr, o_wra, o_pr,
    input  o_pra, o_ref, o_srf, o_pd, o_pdx, o_mrw, o_ckeh, o_ckel,
    input  o_pmode, o_err, o_err_cnt
  );

  modport slave (
    input  i_cke, i_cs_n, i_act_n, i_ras_n, i_cas_n, i_we_n, i_bg, i_ba, i_a10, i_par,
    output o_act, o_rd, o_rda, o_wr, o_wra, o_pr,
    output o_pra, o_ref, o_srf, o_pd, o_pdx, o_mrw, o_ckeh, o_ckel,
    output o_pmode, o_err, o_err_cnt
  );
endinterface

// File: rtl/cmd_decoder.sv
// -----------------------------------------------------------------------------
// cmd_decoder
// Front-end command decoder feeding the per-bank timing FSMs. Command pins are
// registered on edge N, decoded and registered as one-cycle strobes on edge
// N+1. Tracks the rank power mode (NORMAL / PWRDN / SELFREF) so CKE edges are
// classified as power-down / self-refresh entry or exit, and counts illegal
// commands in a saturating 8-bit counter.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : cmd_decoder_if.slave (command pins in, strobes out)
// Optional feature:
//   CMD_PARITY_EN : when defined, even parity over
//                   {act_n, ras_n, cas_n, we_n, bg, ba, a10, par} is checked
//                   on selected NORMAL-mode cycles; a mismatch suppresses the
//                   command and raises err. Without it, par is ignored.
// -----------------------------------------------------------------------------
module cmd_decoder #(
  parameter int BGW    = 2,
  parameter int BAW    = 2,
  parameter int NBANKS = 2**(BGW+BAW)
) (
  input  logic         clk,
  input  logic         rst_n,
  cmd_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    PM_NORMAL  = 2'd0,
    PM_PWRDN   = 2'd1,
    PM_SELFREF = 2'd2
  } pmode_e;

`ifdef CMD_PARITY_EN
  localparam int PW = 4 + BGW + BAW + 2;

  // Even parity: any odd number of ones across the command word is an error.
  function automatic logic f_par_err(input logic [PW-1:0] v);
    return ^v;
  endfunction
`endif

  // Sampled pins (edge N)
  logic              r_cke;
  logic              r_cke_q;
  logic              r_cs_n;
  logic              r_act_n;
  logic              r_ras_n;
  logic              r_cas_n;
  logic              r_we_n;
  logic [BGW-1:0]    r_bg;
  logic [BAW-1:0]    r_ba;
  logic              r_a10;
`ifdef CMD_PARITY_EN
  logic              r_par;
`endif

  // Registered strobes and state (edge N+1)
  logic [NBANKS-1:0] r_act, r_rd, r_rda, r_wr, r_wra, r_pr;
  logic              r_pra, r_ref, r_srf, r_pd, r_pdx, r_mrw, r_ckeh, r_ckel;
  logic              r_err;
  logic [7:0]        r_err_cnt;
  pmode_e            r_pmode;

  // Decode results
  logic [NBANKS-1:0] w_act, w_rd, w_rda, w_wr, w_wra, w_pr;
  logic              w_pra, w_ref, w_srf, w_pd, w_pdx, w_mrw, w_ckeh, w_ckel;
  logic              w_err;
  pmode_e            w_pmode_nxt;

  logic [BGW+BAW-1:0] w_bank;
  logic [2:0]         w_rcw;
  logic               w_sel;
  logic               w_is_nop;
  logic               w_is_ref;
  logic               w_par_bad;

  assign w_bank   = {r_bg, r_ba};
  assign w_rcw    = {r_ras_n, r_cas_n, r_we_n};
  assign w_sel    = ~r_cs_n;
  assign w_is_nop = r_act_n & (w_rcw == 3'b111);
  assign w_is_ref = r_act_n & (w_rcw == 3'b001);

`ifdef CMD_PARITY_EN
  assign w_par_bad = f_par_err({r_act_n, r_ras_n, r_cas_n, r_we_n, r_bg, r_ba, r_a10, r_par});
`else
  assign w_par_bad = 1'b0;
`endif

  // Input sampling stage; cke_q tracks the previously sampled cke.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cke   <= 1'b1;
      r_cke_q <= 1'b1;
      r_cs_n  <= 1'b1;
      r_act_n <= 1'b1;
      r_ras_n <= 1'b1;
      r_cas_n <= 1'b1;
      r_we_n  <= 1'b1;
      r_bg    <= '0;
      r_ba    <= '0;
      r_a10   <= 1'b0;
`ifdef CMD_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_cke   <= bus.i_cke;
      r_cke_q <= r_cke;
      r_cs_n  <= bus.i_cs_n;
      r_act_n <= bus.i_act_n;
      r_ras_n <= bus.i_ras_n;
      r_cas_n <= bus.i_cas_n;
      r_we_n  <= bus.i_we_n;
      r_bg    <= bus.i_bg;
      r_ba    <= bus.i_ba;
      r_a10   <= bus.i_a10;
`ifdef CMD_PARITY_EN
      r_par   <= bus.i_par;
`endif
    end
  end

  // Power-mode next state and command decode; CKE classification wins over
  // command decode so at most one event is reported per cycle.
  always_comb begin
    w_act       = '0;
    w_rd        = '0;
    w_rda       = '0;
    w_wr        = '0;
    w_wra       = '0;
    w_pr        = '0;
    w_pra       = 1'b0;
    w_ref       = 1'b0;
    w_srf       = 1'b0;
    w_pd        = 1'b0;
    w_pdx       = 1'b0;
    w_mrw       = 1'b0;
    w_ckeh      = 1'b0;
    w_ckel      = 1'b0;
    w_err       = 1'b0;
    w_pmode_nxt = r_pmode;

    case (r_pmode)
      PM_NORMAL: begin
        if (!r_cke_q) begin
          // cke low while NORMAL only happens after a rejected entry: NOP.
          w_err = 1'b0;
        end else if (w_sel && w_par_bad) begin
          w_err = 1'b1;
        end else if (!r_cke) begin
          if (!w_sel || w_is_nop) begin
            w_pd        = 1'b1;
            w_ckel      = 1'b1;
            w_pmode_nxt = PM_PWRDN;
          end else if (w_is_ref) begin
            w_srf       = 1'b1;
            w_ckel      = 1'b1;
            w_pmode_nxt = PM_SELFREF;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_sel) begin
          if (!r_act_n) begin
            w_act[w_bank] = 1'b1;
          end else begin
            case (w_rcw)
              3'b000: w_mrw = 1'b1;
              3'b001: w_ref = 1'b1;
              3'b010: begin
                if (r_a10) begin
                  w_pra = 1'b1;
                end else begin
                  w_pr[w_bank] = 1'b1;
                end
              end
              3'b011: w_err = 1'b1;
              3'b100: begin
                if (r_a10) begin
                  w_wra[w_bank] = 1'b1;
                end else begin
                  w_wr[w_bank] = 1'b1;
                end
              end
              3'b101: begin
                if (r_a10) begin
                  w_rda[w_bank] = 1'b1;
                end else begin
                  w_rd[w_bank] = 1'b1;
                end
              end
              default: w_err = 1'b0; // 110 ZQ and 111 NOP carry no strobe
            endcase
          end
        end else begin
          w_err = 1'b0; // deselect
        end
      end
      PM_PWRDN, PM_SELFREF: begin
        // Pins other than cke are ignored while in a low-power mode; cke can
        // only be high here on the rising edge, which is the exit cycle.
        if (!r_cke) begin
          w_ckel = 1'b1;
        end else begin
          if (r_pmode == PM_PWRDN) begin
            w_pdx = 1'b1;
          end else begin
            w_ckeh = 1'b1;
          end
          w_pmode_nxt = PM_NORMAL;
        end
      end
      default: w_pmode_nxt = PM_NORMAL;
    endcase
  end

  // Strobe output registers and power-mode state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act   <= '0;
      r_rd    <= '0;
      r_rda   <= '0;
      r_wr    <= '0;
      r_wra   <= '0;
      r_pr    <= '0;
      r_pra   <= 1'b0;
      r_ref   <= 1'b0;
      r_srf   <= 1'b0;
      r_pd    <= 1'b0;
      r_pdx   <= 1'b0;
      r_mrw   <= 1'b0;
      r_ckeh  <= 1'b0;
      r_ckel  <= 1'b0;
      r_err   <= 1'b0;
      r_pmode <= PM_NORMAL;
    end else begin
      r_act   <= w_act;
      r_rd    <= w_rd;
      r_rda   <= w_rda;
      r_wr    <= w_wr;
      r_wra   <= w_wra;
      r_pr    <= w_pr;
      r_pra   <= w_pra;
      r_ref   <= w_ref;
      r_srf   <= w_srf;
      r_pd    <= w_pd;
      r_pdx   <= w_pdx;
      r_mrw   <= w_mrw;
      r_ckeh  <= w_ckeh;
      r_ckel  <= w_ckel;
      r_err   <= w_err;
      r_pmode <= w_pmode_nxt;
    end
  end

  // Saturating illegal-command counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  assign bus.o_act     = r_act;
  assign bus.o_rd      = r_rd;
  assign bus.o_rda     = r_rda;
  assign bus.o_wr      = r_wr;
  assign bus.o_wra     = r_wra;
  assign bus.o_pr      = r_pr;
  assign bus.o_pra     = r_pra;
  assign bus.o_ref     = r_ref;
  assign bus.o_srf     = r_srf;
  assign bus.o_pd      = r_pd;
  assign bus.o_pdx     = r_pdx;
  assign bus.o_mrw     = r_mrw;
  assign bus.o_ckeh    = r_ckeh;
  assign bus.o_ckel    = r_ckel;
  assign bus.o_pmode   = r_pmode;
  assign bus.o_err     = r_err;
  assign bus.o_err_cnt = r_err_cnt;

endmodule
